// File: rtl/sysarr_ctrl_pkg.sv
// Shared constants, state encodings and element-index helpers for the 3x3 systolic sequencer.
package sysarr_ctrl_pkg;

  localparam int unsigned DIM         = 3;
  localparam int unsigned NUM_ELEM    = DIM * DIM;
  localparam int unsigned FEED_CYCLES = 2 * DIM - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Row-major flat index of element (row, col).
  function automatic logic [3:0] elem_idx(input int unsigned row, input int unsigned col);
    return 4'(row * DIM + col);
  endfunction

  // True when idx addresses a real matrix element.
  function automatic logic idx_valid(input logic [3:0] idx);
    return idx < 4'(NUM_ELEM);
  endfunction

endpackage

// File: rtl/sysarr_ctrl_if.sv
// Host and array-edge signal bundle; slave is the sequencer's view, master the driver's view.
interface sysarr_ctrl_if
  import sysarr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic                         wr_en;
  logic                         wr_sel;
  logic [3:0]                   wr_idx;
  logic [WIDTH-1:0]             wr_data;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         feed_valid;
  logic [DIM*WIDTH-1:0]         a_feed;
  logic [DIM*WIDTH-1:0]         b_feed;
  logic [NUM_ELEM*WIDTH-1:0]    res_in;
  logic [3:0]                   rd_idx;
  logic [WIDTH-1:0]             rd_data;

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start, res_in, rd_idx,
    output busy, done, feed_valid, a_feed, b_feed, rd_data
  );

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start, res_in, rd_idx,
    input  busy, done, feed_valid, a_feed, b_feed, rd_data
  );

endinterface

// File: rtl/sysarr_skew_lane.sv
// One skewed edge lane: lane n presents word (t - n) of its vector, or zero outside the window.
module sysarr_skew_lane
  import sysarr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANE  = 0
) (
  input  logic             en,
  input  logic [2:0]       t,
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] word
);

  localparam logic [2:0] LANE3 = 3'(LANE);

  logic [2:0] off;

  assign off = t - LANE3;

  // Select the word whose diagonal reaches this lane at step t.
  always_comb begin
    word = '0;
    if (en && (t >= LANE3) && (off < 3'(DIM))) begin
      case (off)
        3'd0:    word = w0;
        3'd1:    word = w1;
        default: word = w2;
      endcase
    end
  end

endmodule

// File: rtl/sysarr_ctrl.sv
// Sequencer for the 3x3 systolic array: holds A/B, streams skewed edges, captures C after latency.
module sysarr_ctrl
  import sysarr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ARR_LAT = 7
) (
  input logic         clock,
  input logic         reset,
  sysarr_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W    = (ARR_LAT > 1) ? $clog2(ARR_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (ARR_LAT > 0) ? CNT_W'(ARR_LAT - 1) : '0;
  localparam logic [2:0]       T_LAST   = 3'(FEED_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [2:0]           t_q, t_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 capture;
  logic                 wr_ok;
  logic                 feed_en;

  logic [WIDTH-1:0]     a_q [NUM_ELEM];
  logic [WIDTH-1:0]     a_d [NUM_ELEM];
  logic [WIDTH-1:0]     b_q [NUM_ELEM];
  logic [WIDTH-1:0]     b_d [NUM_ELEM];
  logic [WIDTH-1:0]     c_q [NUM_ELEM];

  logic [DIM*WIDTH-1:0] a_feed_q, a_feed_d;
  logic [DIM*WIDTH-1:0] b_feed_q, b_feed_d;

  assign wr_ok = bus.wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                 idx_valid(bus.wr_idx);

  // Bank next-state; a write in the start cycle is already visible to the first feed step.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_ok) begin
      if (bus.wr_sel) b_d[bus.wr_idx] = bus.wr_data;
      else            a_d[bus.wr_idx] = bus.wr_data;
    end
  end

  // Sequencer next-state: feed step counter, drain counter and capture strobe.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FEED;
          t_d     = '0;
        end
      end
      ST_FEED: begin
        if (t_q == T_LAST) begin
          if (ARR_LAT == 0) begin
            state_d = ST_DONE;
            capture = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  // Feeds are registered, so lanes are computed from next-cycle state and step.
  assign feed_en = (state_d == ST_FEED);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    sysarr_skew_lane #(
      .WIDTH (WIDTH),
      .LANE  (i)
    ) u_a_lane (
      .en   (feed_en),
      .t    (t_d),
      .w0   (a_d[elem_idx(i, 0)]),
      .w1   (a_d[elem_idx(i, 1)]),
      .w2   (a_d[elem_idx(i, 2)]),
      .word (a_feed_d[i*WIDTH +: WIDTH])
    );

    sysarr_skew_lane #(
      .WIDTH (WIDTH),
      .LANE  (i)
    ) u_b_lane (
      .en   (feed_en),
      .t    (t_d),
      .w0   (b_d[elem_idx(0, i)]),
      .w1   (b_d[elem_idx(1, i)]),
      .w2   (b_d[elem_idx(2, i)]),
      .word (b_feed_d[i*WIDTH +: WIDTH])
    );
  end

  // Control state and registered edge feeds.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      cnt_q    <= '0;
      a_feed_q <= '0;
      b_feed_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      a_feed_q <= a_feed_d;
      b_feed_q <= b_feed_d;
    end
  end

  // Operand banks and the C result bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      if (capture) begin
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
          c_q[k] <= bus.res_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.busy       = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.feed_valid = (state_q == ST_FEED);
  assign bus.a_feed     = a_feed_q;
  assign bus.b_feed     = b_feed_q;

  // Combinational C read; out-of-range indices read as zero.
  always_comb begin
    bus.rd_data = '0;
    if (idx_valid(bus.rd_idx)) bus.rd_data = c_q[bus.rd_idx];
  end

endmodule

// File: doc/sysarr_ctrl.md
Name: sysarr_ctrl

Overview:
Sequencer for the 3x3 integer systolic array. It holds operand matrices A and B written by a host. On start, it streams A rows and B columns into the array's edge inputs with diagonal skew. It then waits for the fixed array latency, captures the nine result words into a readable C bank, and pulses done.

Parameters:
WIDTH, 32, data word width for operands and results.
ARR_LAT, 7, cycles from the last feed cycle to the cycle in which res_in is valid.
DIM, 3, array dimension (fixed at 3; other values unsupported).

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  host operand write strobe.
wr_sel  input  1  0 = write A, 1 = write B.
wr_idx  input  4  row-major element index 0..8 (row = idx/3, col = idx%3).
wr_data  input  WIDTH  operand word.
start  input  1  begin a multiply; honoured only in IDLE.
busy  output  1  high in FEED and DRAIN.
done  output  1  one-cycle pulse in DONE.
feed_valid  output  1  high during the 5 FEED cycles.
a_feed  output  3*WIDTH  lane i at bits [i*WIDTH +: WIDTH]; drives array row-i A input.
b_feed  output  3*WIDTH  lane j; drives array column-j B input.
res_in  input  9*WIDTH  array C outputs; element k at [k*WIDTH +: WIDTH], row-major.
rd_idx  input  4  C read index 0..8.
rd_data  output  WIDTH  combinational read of captured C[rd_idx]; 0 if rd_idx > 8.

Behaviour:
- Reset clears all state and outputs:
  - State goes to IDLE; the A, B and C banks are all zeroed.
  - busy, done, feed_valid = 0; a_feed, b_feed = 0.
  - Reset wins over every other input in the same cycle, including mid-FEED and mid-DRAIN. An aborted run never pulses done.
- States: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
- Writes:
  - Accepted only in IDLE (and DONE); ignored while busy.
  - wr_idx > 8 is ignored.
  - A write in the same cycle as an accepted start is committed and is visible to the run.
- IDLE: start=1 moves to FEED, with feed counter t = 0 on the next cycle.
- FEED (t = 0..4, 2*DIM-1 cycles), feed_valid = 1:
  - a_feed lane i = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - b_feed lane j = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - Outputs are registered. They show the value for t in the cycle labelled t.
- DRAIN:
  - Counts ARR_LAT cycles with a_feed, b_feed = 0.
  - On the last DRAIN cycle, res_in is latched into the C bank.
  - ARR_LAT = 0 means capture happens in the cycle after t = 4.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
  - start in DONE is ignored. start must be re-asserted in IDLE.
- Latency:
  - start is sampled on edge E.
  - done is high in cycle E + 1 + 5 + ARR_LAT.
  - The C bank is updated at the edge that begins DONE.
- start held high continuously: runs repeat back-to-back, separated by one IDLE cycle.
- C bank holds its contents until the next capture or reset. rd_data is valid in any state.
- No arithmetic in this block. Words pass through unmodified and are zero-padded outside the skew window.

Decomposition:
- Shared package/header:
  - State encodings (IDLE=0, FEED=1, DRAIN=2, DONE=3).
  - DIM = 3.
  - FEED_CYCLES = 2*DIM-1.
  - Element-index helpers.
- One sub-module, sysarr_skew_lane.
  - Given t, lane number and three words, it outputs the skewed word or 0.
  - Instantiated 3x for A and 3x for B.

Test Plan:
- Reset: assert reset for 2 cycles after arbitrary writes -> busy = done = feed_valid = 0, feeds 0, rd_data = 0 for all idx.
- Skew pattern, A = 1..9 row-major, start -> a_feed lanes (0,1,2) per t:
  - t0 (1,0,0), t1 (2,4,0), t2 (3,5,7), t3 (0,6,8), t4 (0,0,9).
  - b_feed with B = 1..9: t0 (1,0,0), t1 (4,2,0), t2 (7,5,3), t3 (0,8,6), t4 (0,0,9).
- End-to-end with the array model, A = 1..9, B = 9..1 row-major:
  - done arrives at E + 6 + ARR_LAT.
  - C reads 30, 24, 18, 84, 69, 54, 138, 114, 90.
- Busy lockout: wr_en to A[0] = 99 and a second start during FEED -> ignored. A[0] is still 1 on the next run and only one done pulse is seen.
- Mid-run reset: reset at t = 2 of FEED -> IDLE next cycle, no done, C bank = 0, feeds zero.
- Same-cycle write + start: write A[4] = 50 with start in IDLE -> lane 1 emits 50 at t = 2.
